inst_encoder: RTL

Sequential RISC-V instruction encoder: accepts decoded instruction fields plus a full 32-bit signed immediate and packs them into legal RV32I instruction words. It performs the inverse of the core's immediate generation, including per-format range and alignment checks. Accepted words are buffered in a small FIFO and streamed out with a word address for loading instruction memory. It sits in the test/boot path, ahead of instruction memory.

---
 rtl/inst_encoder_if.sv | 33 +++
 rtl/inst_encoder.sv | 81 ++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field-bundle input, instruction-word output and status bundle for inst_encoder.
interface inst_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_init;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [1:0]        err_code;
    logic [CW-1:0]     count;
    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, addr_load, addr_init, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err, err_code, count
    );
    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, addr_load, addr_init, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err, err_code, count
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded fields into RV32I words, range-checks immediates, queues words with addresses.
module inst_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 9
) (
    input logic           clk,
    input logic           rst_n,
    inst_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic              rst_n_q;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       inst;
    logic [1:0]        code;
    logic              is_i, is_s, is_b, is_j, is_r;
    logic              fit_11, fit_12, fit_20;
    logic              acc, push, pop;
    always_comb begin
        is_i   = bus.opcode == 7'b0000011 || bus.opcode == 7'b0010011 || bus.opcode == 7'b1100111;
        is_s   = bus.opcode == 7'b0100011;
        is_b   = bus.opcode == 7'b1100011;
        is_j   = bus.opcode == 7'b1101111;
        is_r   = bus.opcode == 7'b0110011;
        fit_11 = &bus.imm[31:11] || ~|bus.imm[31:11];
        fit_12 = &bus.imm[31:12] || ~|bus.imm[31:12];
        fit_20 = &bus.imm[31:20] || ~|bus.imm[31:20];
        inst   = is_s ? {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode} :
                 is_b ? {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:1], bus.imm[11], bus.opcode} :
                 is_j ? {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode} :
                 is_r ? {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode} :
                        {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        // unsupported outranks misaligned, which outranks out-of-range
        code   = !(is_i || is_s || is_b || is_j || is_r)                  ? 2'b01 :
                 (is_b || is_j) && bus.imm[0]                             ? 2'b11 :
                 ((is_i || is_s) && !fit_11) || (is_b && !fit_12) || (is_j && !fit_20) ? 2'b10 : 2'b00;
        acc     = bus.in_valid && bus.in_ready;
        push    = acc && code == 2'b00;
        pop     = bus.out_valid && bus.out_ready;
        count_d = count_q + CW'(push) - CW'(pop);
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        addr_d  = bus.addr_load ? bus.addr_init : addr_q + ADDR_W'(pop);
        err_d   = acc && code != 2'b00;
        code_d  = err_d ? code : code_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            rst_n_q <= 1'b1;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= inst;
    end
    assign bus.in_ready  = rst_n_q && count_q < CW'(DEPTH);
    assign bus.out_valid = count_q != '0;
    assign bus.out_inst  = bus.out_valid ? mem_q[rptr_q] : '0;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.count     = count_q;
endmodule
